rat_intr_ctrl: RTL and testbench

Multi-source interrupt controller for the RAT MCU. It merges up to 8 peripheral interrupt sources onto the MCU's single `interrupt` input. Sources use fixed priority and can be masked individually. The ISR identifies and acknowledges the active source through the MCU's existing IN/OUT port space (`port_id`, `out_port`, `io_strb`, `in_port`). The block sits beside the MCU at top level; its read data is muxed into `in_port`.

---
 rtl/rat_intr_ctrl.sv | 149 ++++++++++++++
 tb/tb_rat_intr_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_intr_ctrl.sv
// ============================================================================
// Module   : rat_intr_ctrl
// Purpose  : Fixed-priority, maskable 8-source interrupt controller for the
//            RAT MCU, identified and acknowledged through IN/OUT port space.
// Option   : define RAT_INTR_SYNC_EN to add 2-flop source synchronizers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rat_intr_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] ID_PORT   = 8'hF0,
  parameter logic [7:0] PEND_PORT = 8'hF1,
  parameter logic [7:0] MASK_PORT = 8'hF2,
  parameter logic [7:0] ACK_PORT  = 8'hF3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               io_strb,
  output logic               intr_out,
  output logic [7:0]         rd_data,
  output logic               rd_hit
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [2:0]         r_cur_id;
  logic [2:0]         w_cur_nxt;
  logic               r_intr;
  logic [NUM_SRC-1:0] w_src;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_clr;
  logic [2:0]         w_arb_id;
  logic               w_mask_wr;
  logic               w_ack_wr;

`ifdef RAT_INTR_SYNC_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = src_in;
`endif

  assign w_rise     = w_src & ~r_src_q;
  assign w_eligible = r_pending & r_mask;
  assign w_mask_wr  = io_strb && (port_id == MASK_PORT);
  assign w_ack_wr   = io_strb && (port_id == ACK_PORT);

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_arb_id = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_arb_id = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_id;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt = ST_REQ;
          w_cur_nxt   = w_arb_id;
        end
      end
      ST_REQ: begin
        if (w_ack_wr) begin
          w_state_nxt = ST_GAP;
          for (int i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = (r_cur_id == 3'(i));
          end
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // A new rise on the acknowledged source survives the clear (set wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_src_q   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_cur_id  <= 3'd0;
      r_intr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src_q   <= w_src;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_cur_id  <= w_cur_nxt;
      r_intr    <= (w_state_nxt == ST_REQ);
      if (w_mask_wr) begin
        r_mask <= out_port[NUM_SRC-1:0];
      end
    end
  end

  assign intr_out = r_intr;

  always_comb begin
    rd_data = 8'h00;
    rd_hit  = 1'b0;
    if (port_id == ID_PORT) begin
      rd_data = {(r_state == ST_REQ), 4'b0000, r_cur_id};
      rd_hit  = 1'b1;
    end else if (port_id == PEND_PORT) begin
      rd_data = 8'(r_pending);
      rd_hit  = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the controller.
`default_nettype none

module tb_rat_intr_ctrl;

  localparam int         N    = 8;
  localparam logic [7:0] P_ID = 8'hF0;
  localparam logic [7:0] P_PD = 8'hF1;
  localparam logic [7:0] P_MK = 8'hF2;
  localparam logic [7:0] P_AK = 8'hF3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_in;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic       intr_out;
  logic [7:0] rd_data;
  logic       rd_hit;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  always #10 clk = ~clk;

  rat_intr_ctrl #(
    .NUM_SRC  (N),
    .ID_PORT  (P_ID),
    .PEND_PORT(P_PD),
    .MASK_PORT(P_MK),
    .ACK_PORT (P_AK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .src_in  (src_in),
    .port_id (port_id),
    .out_port(out_port),
    .io_strb (io_strb),
    .intr_out(intr_out),
    .rd_data (rd_data),
    .rd_hit  (rd_hit)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending set of requests, one in-service slot, one-cycle gap flag.
  logic [7:0] m_pend, m_mask, m_prev;
  logic [2:0] m_cur;
  logic       m_req, m_gap;
`ifdef RAT_INTR_SYNC_EN
  logic [7:0] m_s1, m_s2;
`endif

  always @(posedge clk or posedge reset) begin
    logic [7:0] seen, rise, np;
    int first;
    if (reset) begin
      m_pend <= 8'h00; m_mask <= 8'h00; m_prev <= 8'h00;
      m_cur <= 3'd0; m_req <= 1'b0; m_gap <= 1'b0;
`ifdef RAT_INTR_SYNC_EN
      m_s1 <= 8'h00; m_s2 <= 8'h00;
`endif
    end else begin
`ifdef RAT_INTR_SYNC_EN
      m_s1 <= src_in; m_s2 <= m_s1;
      seen = m_s2;
`else
      seen = src_in;
`endif
      rise = seen & ~m_prev;
      np   = m_pend | rise;
      if (m_gap) begin
        m_gap <= 1'b0;
      end else if (m_req) begin
        if (io_strb && port_id == P_AK) begin
          np = (m_pend & ~(8'd1 << m_cur)) | rise;
          m_req <= 1'b0;
          m_gap <= 1'b1;
        end
      end else begin
        first = -1;
        for (int i = 0; i < N; i++)
          if (first < 0 && m_pend[i] && m_mask[i]) first = i;
        if (first >= 0) begin
          m_cur <= 3'(first);
          m_req <= 1'b1;
        end
      end
      m_pend <= np;
      m_prev <= seen;
      if (io_strb && port_id == P_MK) m_mask <= out_port;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_rd;
    logic       e_hit;
    if (checking) begin
      e_rd  = 8'h00;
      e_hit = 1'b0;
      if (port_id == P_ID) begin
        e_rd = {m_req, 4'b0000, m_cur}; e_hit = 1'b1;
      end else if (port_id == P_PD) begin
        e_rd = m_pend; e_hit = 1'b1;
      end
      chk("model_intr", {7'd0, intr_out}, {7'd0, m_req});
      chk("model_rd_data", rd_data, e_rd);
      chk("model_rd_hit", {7'd0, rd_hit}, {7'd0, e_hit});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_out(input logic [7:0] p, input logic [7:0] d);
    io_strb = 1'b1; port_id = p; out_port = d;
    tick();
    io_strb = 1'b0; port_id = 8'h00;
  endtask

  task automatic rd(input logic [7:0] p, input logic [7:0] exp, input string name);
    port_id = p;
    #1;
    chk(name, rd_data, exp);
    chk({name, "_hit"}, {7'd0, rd_hit}, 8'h01);
    port_id = 8'h00;
  endtask

  task automatic chk_intr(input logic e, input string name);
    chk(name, {7'd0, intr_out}, {7'd0, e});
  endtask

  initial begin
    int r;
    reset = 1'b1; src_in = 8'h00; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checking = 1'b1;
    chk_intr(1'b0, "reset_intr");
    rd(P_ID, 8'h00, "reset_id");
    rd(P_PD, 8'h00, "reset_pend");

    // Single source, full mask.
    do_out(P_MK, 8'hFF);
    src_in = 8'h08; tick(); src_in = 8'h00;
    chk_intr(1'b0, "t1_intr_after_E0");
    tick();
    chk_intr(1'b1, "t1_intr_after_E1");
    rd(P_ID, 8'h83, "t1_id");
    rd(P_PD, 8'h08, "t1_pend");

    // Acknowledge and gap.
    do_out(P_AK, 8'h5A);
    chk_intr(1'b0, "t2_intr_gap");
    rd(P_PD, 8'h00, "t2_pend");
    tick(); chk_intr(1'b0, "t2_intr_idle");
    tick(); chk_intr(1'b0, "t2_intr_stays_low");

    // Two simultaneous sources: priority order.
    src_in = 8'h22; tick(); src_in = 8'h00; tick();
    rd(P_ID, 8'h81, "t3_id_first");
    do_out(P_AK, 8'h00); chk_intr(1'b0, "t3_gap");
    tick(); chk_intr(1'b0, "t3_idle");
    tick(); chk_intr(1'b1, "t3_second_req");
    rd(P_ID, 8'h85, "t3_id_second");
    do_out(P_AK, 8'h00); tick(); tick();

    // Masked request is held, then released by a mask write.
    do_out(P_MK, 8'h00);
    src_in = 8'h04; tick(); src_in = 8'h00; tick(); tick();
    chk_intr(1'b0, "t4_masked_intr");
    rd(P_PD, 8'h04, "t4_pend_held");
    do_out(P_MK, 8'h04);
    chk_intr(1'b0, "t4_old_mask_used");
    tick(); chk_intr(1'b1, "t4_unmasked_intr");
    rd(P_ID, 8'h82, "t4_id");

    // Rise of the in-service source together with its ACK.
    src_in = 8'h04;
    do_out(P_AK, 8'h00);
    src_in = 8'h00;
    chk_intr(1'b0, "t5_gap");
    rd(P_PD, 8'h04, "t5_pend_kept");
    tick(); chk_intr(1'b0, "t5_idle");
    tick(); chk_intr(1'b1, "t5_reserviced");
    rd(P_ID, 8'h82, "t5_id");
    do_out(P_AK, 8'h00); tick(); tick();

    // Asynchronous reset in REQ.
    src_in = 8'h04; tick(); src_in = 8'h00; tick();
    chk_intr(1'b1, "t6_in_req");
    #2 reset = 1'b1;
    #1 chk_intr(1'b0, "t6_async_drop");
    rd(P_PD, 8'h00, "t6_pend_cleared");
    #1 reset = 1'b0;
    src_in = 8'h02; tick(); src_in = 8'h00; tick(); tick();
    chk_intr(1'b0, "t6_mask_cleared");
    rd(P_PD, 8'h02, "t6_pend_after");
    do_out(P_AK, 8'h00);
    rd(P_PD, 8'h02, "t6_ack_ignored");
    chk_intr(1'b0, "t6_intr_after_ack");

    // Randomized traffic checked by the model each cycle.
    repeat (3000) begin
      src_in = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4) begin
        io_strb  = 1'b1;
        out_port = 8'($urandom);
        case ($urandom_range(0, 5))
          0: port_id = P_ID;
          1: port_id = P_PD;
          2: port_id = P_MK;
          3, 4: port_id = P_AK;
          default: port_id = 8'($urandom);
        endcase
      end else begin
        io_strb = 1'b0;
        out_port = 8'($urandom);
        case ($urandom_range(0, 2))
          0: port_id = P_ID;
          1: port_id = P_PD;
          default: port_id = 8'($urandom);
        endcase
      end
      tick();
    end
    io_strb = 1'b0;
    tick();
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
